// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// The priority search is a pure function, so the FSM can stay compact.
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  // Returns the first requesting client at or after ptr (wrapping 7->0).
  // The loop walks downward in distance, so the closest requester is written last and wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb8_if.sv
// Client-facing bundle of the arbiter: requests and release in, grant status out.
interface rr_arb8_if;
  import rr_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               timeout;

  modport master (output req, done, input gnt, gnt_idx, gnt_vld, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/dec3_8.sv
// 3-to-8 one-hot decoder used to turn a client index into a select strobe.
module dec3_8 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);
  assign dec = 8'd1 << sel;
endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter with done / request-drop / hold-timeout release.
//   state | meaning
//   IDLE  | no grant; search from ptr for the next requester
//   GRANT | gnt_idx owns the resource until done, req drop or MAX_HOLD
module rr_arb8 #(
  parameter int HOLD_W   = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_arb8_if.slave  arb
);
  import rr_arb_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic               gnt_vld_q;
  logic               timeout_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [IDX_W-1:0]   pick;
  logic [NUM_REQ-1:0] dec_out;
  logic               rel_now;
  logic               rel_timeout;

  assign pick = rr_pick(arb.req, ptr);

  // done outranks the timeout, so a coincident done never pulses timeout.
  always_comb begin
    rel_now     = 1'b0;
    rel_timeout = 1'b0;
    if (state == GRANT) begin
      if (arb.done || !arb.req[gnt_idx_q]) begin
        rel_now = 1'b1;
      end else if (hold_cnt == HOLD_LIMIT) begin
        rel_now     = 1'b1;
        rel_timeout = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb.req) begin
            gnt_idx_q <= pick;
            gnt_vld_q <= 1'b1;
            hold_cnt  <= HOLD_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (rel_now) begin
            gnt_vld_q <= 1'b0;
            ptr       <= gnt_idx_q + IDX_W'(1);
            hold_cnt  <= '0;
            timeout_q <= rel_timeout;
            state     <= IDLE;
          end else if (hold_cnt != HOLD_LIMIT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dec3_8 u_dec (
    .sel (gnt_idx_q),
    .dec (dec_out)
  );

  assign arb.gnt     = gnt_vld_q ? dec_out : '0;
  assign arb.gnt_idx = gnt_idx_q;
  assign arb.gnt_vld = gnt_vld_q;
  assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Randomized scoreboard bench for rr_arb8 against a cycle-level behavioural model.
module tb_rr_arb8;
  localparam int MAXH = 3;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t e;

  // behavioural model: who holds the resource, for how long, and where the search starts
  bit   m_busy;
  int   m_who;
  int   m_held;
  int   m_ptr;
  bit   m_to;

  rr_arb8_if arb ();

  rr_arb8 #(.HOLD_W(4), .MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_who = 0; m_held = 0; m_ptr = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    exp_t x;
    int   w;
    m_to = 0;
    if (!m_busy) begin
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && r[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      if (w >= 0) begin
        m_busy = 1; m_who = w; m_held = 1;
      end
    end else if (d || !r[m_who]) begin
      m_busy = 0; m_ptr = (m_who + 1) % 8;
    end else if (m_held >= MAXH) begin
      m_busy = 0; m_ptr = (m_who + 1) % 8; m_to = 1;
    end else begin
      m_held++;
    end
    x.gnt = m_busy ? 8'(1 << m_who) : 8'h00;
    x.idx = 3'(m_who);
    x.vld = m_busy;
    x.to  = m_to;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    arb.req  = r;
    arb.done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req_v);
    tests++;
    if (act != req_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (arb.gnt !== e.gnt || arb.gnt_vld !== e.vld || arb.timeout !== e.to ||
          (e.vld && arb.gnt_idx !== e.idx)) begin
        fails++;
        $display("FAIL outputs @%0t: gnt=%h idx=%0d vld=%b to=%b expected gnt=%h idx=%0d vld=%b to=%b",
                 $time, arb.gnt, arb.gnt_idx, arb.gnt_vld, arb.timeout,
                 e.gnt, e.idx, e.vld, e.to);
      end
    end
  end

  initial begin
    logic [7:0] rr;
    arb.req  = 8'h00;
    arb.done = 1'b0;
    model_reset();
    #3;
    chk("reset_gnt", int'(arb.gnt), 0);
    chk("reset_vld", int'(arb.gnt_vld), 0);
    chk("reset_idx", int'(arb.gnt_idx), 0);
    chk("reset_to", int'(arb.timeout), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // grant client 2, then reset between edges
    step(8'h04, 0);
    step(8'h04, 0);
    #1 rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("midreset_gnt", int'(arb.gnt), 0);
    chk("midreset_vld", int'(arb.gnt_vld), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(8'h01, 0);
    step(8'h01, 0);
    step(8'h00, 0);
    step(8'h00, 0);

    // single requester with done on the 3rd grant cycle (coincides with MAX_HOLD=3)
    step(8'h10, 0);
    step(8'h10, 0);
    step(8'h10, 0);
    step(8'h10, 1);
    for (int i = 0; i < 4; i++) step(8'h10, 0);
    step(8'h00, 0);
    step(8'h00, 0);

    // wrap and skip: grant 5, release, then req=05
    step(8'h20, 0);
    step(8'h20, 1);
    for (int i = 0; i < 3; i++) step(8'h05, 0);
    step(8'h05, 1);
    for (int i = 0; i < 3; i++) step(8'h05, 0);
    step(8'h00, 0);
    step(8'h00, 0);

    // request drop: client 3 then client 7
    step(8'h08, 0);
    step(8'h88, 0);
    step(8'h88, 0);
    for (int i = 0; i < 5; i++) step(8'h80, 0);
    step(8'h00, 0);

    // fairness: everyone requesting, no done
    for (int i = 0; i < 8 * (MAXH + 1) + 4; i++) step(8'hFF, 0);

    // random traffic
    rr = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) rr = 8'($urandom);
      step(rr, $urandom_range(0, 7) == 0);
    end
    step(8'h00, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
